// File: rtl/riscv_ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package riscv_ifetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DROP
  } IF_STATE;

  typedef enum logic [1:0] {
    FF_NONE     = 2'd0,
    FF_MISALIGN = 2'd1,
    FF_TIMEOUT  = 2'd2
  } FETCH_FAULT;

  // addi x0, x0, 0 -- harmless no-op handed to decode on faults.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/riscv_ifetch_if.sv
// Memory request/response channel and decode handshake of the fetch stage.
interface riscv_ifetch_if
  import riscv_ifetch_pkg::*;
#(
  parameter int WORD_LENGTH = 32
) ();

  logic                   imem_req_valid;
  logic                   imem_req_ready;
  logic [WORD_LENGTH-1:0] imem_addr;
  logic                   imem_rsp_valid;
  logic [WORD_LENGTH-1:0] imem_rsp_data;

  logic                   inst_valid;
  logic                   inst_ready;
  logic [WORD_LENGTH-1:0] inst;
  logic [WORD_LENGTH-1:0] inst_pc;
  logic                   inst_fault;
  FETCH_FAULT             fault_cause;

  // master is the fetch stage; slave is the memory plus decode side.
  modport master (
    output imem_req_valid, imem_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output inst_valid, inst, inst_pc, inst_fault, fault_cause,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  inst_valid, inst, inst_pc, inst_fault, fault_cause,
    output inst_ready
  );

endinterface

// File: rtl/riscv_ifetch_watchdog.sv
// Saturating cycle counter that flags a memory response as overdue.
module riscv_ifetch_watchdog #(
  parameter int MAX_COUNT = 255
) (
  input  logic clk,
  input  logic x_reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int WIDTH = $clog2(MAX_COUNT + 1);
  localparam logic [WIDTH-1:0] LIMIT = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] count;

  // Holds at LIMIT rather than wrapping so a late response can never re-arm it.
  always_ff @(posedge clk or negedge x_reset) begin
    if (!x_reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + WIDTH'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/riscv_ifetch.sv
// Instruction fetch stage: one outstanding imem read, result held for decode,
// stale responses dropped after a redirect, misalign/timeout faults reported.
module riscv_ifetch
  import riscv_ifetch_pkg::*;
#(
  parameter int WORD_LENGTH    = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   x_reset,
  input  logic [WORD_LENGTH-1:0] pc,
  input  logic                   flush,
  output logic                   pc_stall,
  riscv_ifetch_if.master         bus
);

  IF_STATE                state;
  IF_STATE                next_state;
  logic [WORD_LENGTH-1:0] req_pc;
  logic [WORD_LENGTH-1:0] load_pc;
  logic                   misaligned;
  logic                   req_fire;
  logic                   load_rsp;
  logic                   load_fault;
  logic                   clear_valid;
  FETCH_FAULT             load_cause;
  logic                   wd_clear;
  logic                   wd_enable;
  logic                   wd_expired;

  assign misaligned         = is_misaligned(pc[1:0]);
  assign bus.imem_req_valid = (state == REQ) && !misaligned;
  assign bus.imem_addr      = pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;
  assign pc_stall           = !(bus.inst_valid && bus.inst_ready);

  // The watchdog restarts whenever a response wait (WAIT or DROP) begins.
  assign wd_enable = (state == WAIT) || (state == DROP);
  assign wd_clear  = ((next_state == WAIT) || (next_state == DROP)) && (next_state != state);

  riscv_ifetch_watchdog #(
    .MAX_COUNT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .x_reset(x_reset),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  always_ff @(posedge clk or negedge x_reset) begin
    if (!x_reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    load_rsp    = 1'b0;
    load_fault  = 1'b0;
    load_cause  = FF_NONE;
    load_pc     = req_pc;
    clear_valid = 1'b0;
    case (state)
      IDLE: next_state = REQ;
      REQ: begin
        if (misaligned) begin
          load_fault = 1'b1;
          load_cause = FF_MISALIGN;
          load_pc    = pc;
          next_state = HOLD;
        end else if (req_fire) begin
          next_state = flush ? DROP : WAIT;
        end
      end
      WAIT: begin
        // A redirect wins over both data and timeout; same-cycle data retires the request.
        if (flush) begin
          next_state = bus.imem_rsp_valid ? REQ : DROP;
        end else if (bus.imem_rsp_valid) begin
          load_rsp   = 1'b1;
          next_state = HOLD;
        end else if (wd_expired) begin
          load_fault = 1'b1;
          load_cause = FF_TIMEOUT;
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (flush || bus.inst_ready) begin
          clear_valid = 1'b1;
          next_state  = REQ;
        end
      end
      DROP: begin
        if (bus.imem_rsp_valid || wd_expired) begin
          next_state = REQ;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge x_reset) begin
    if (!x_reset) begin
      req_pc          <= '0;
      bus.inst_valid  <= 1'b0;
      bus.inst        <= WORD_LENGTH'(NOP_INST);
      bus.inst_pc     <= '0;
      bus.inst_fault  <= 1'b0;
      bus.fault_cause <= FF_NONE;
    end else begin
      if (req_fire) begin
        req_pc <= pc;
      end
      if (load_rsp) begin
        bus.inst_valid  <= 1'b1;
        bus.inst        <= bus.imem_rsp_data;
        bus.inst_pc     <= req_pc;
        bus.inst_fault  <= 1'b0;
        bus.fault_cause <= FF_NONE;
      end else if (load_fault) begin
        bus.inst_valid  <= 1'b1;
        bus.inst        <= WORD_LENGTH'(NOP_INST);
        bus.inst_pc     <= load_pc;
        bus.inst_fault  <= 1'b1;
        bus.fault_cause <= load_cause;
      end else if (clear_valid) begin
        bus.inst_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_riscv_ifetch.sv
// Directed bench for riscv_ifetch: stimulus queues expected instructions and a
// forked monitor compares every instruction that decode consumes.
module tb_riscv_ifetch;
  import riscv_ifetch_pkg::*;

  localparam int WL = 32;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
    logic [1:0]  cause;
  } exp_t;

  logic        clk;
  logic        x_reset;
  logic [31:0] pc;
  logic        flush;
  logic        pc_stall;

  int   n_checks;
  int   n_pass;
  exp_t exp_q[$];

  riscv_ifetch_if #(.WORD_LENGTH(WL)) bus ();

  riscv_ifetch #(
    .WORD_LENGTH   (WL),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk     (clk),
    .x_reset (x_reset),
    .pc      (pc),
    .flush   (flush),
    .pc_stall(pc_stall),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [31:0] new_pc, input logic new_flush,
                                input logic req_ready, input logic rsp_valid,
                                input logic [31:0] rsp_data, input logic dec_ready);
    pc                 = new_pc;
    flush              = new_flush;
    bus.imem_req_ready = req_ready;
    bus.imem_rsp_valid = rsp_valid;
    bus.imem_rsp_data  = rsp_data;
    bus.inst_ready     = dec_ready;
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_inst_valid"}, 32'(bus.inst_valid), 32'h0);
    check_output({tag, "_inst"}, bus.inst, NOP_INST);
    check_output({tag, "_inst_pc"}, bus.inst_pc, 32'h0);
    check_output({tag, "_inst_fault"}, 32'(bus.inst_fault), 32'h0);
    check_output({tag, "_fault_cause"}, 32'(bus.fault_cause), 32'h0);
    check_output({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'h0);
    check_output({tag, "_pc_stall"}, 32'(pc_stall), 32'h1);
  endtask

  // Every consumed instruction must match the oldest queued expectation.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (x_reset && bus.inst_valid && bus.inst_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("[TB] FAIL sb_unexpected: got inst 0x%08h pc 0x%08h, expected no instruction",
                   bus.inst, bus.inst_pc);
        end else begin
          e = exp_q.pop_front();
          check_output("sb_inst", bus.inst, e.inst);
          check_output("sb_pc", bus.inst_pc, e.pc);
          check_output("sb_fault", 32'(bus.inst_fault), 32'(e.fault));
          check_output("sb_cause", 32'(bus.fault_cause), 32'(e.cause));
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    x_reset  = 1'b0;
    apply_stimulus(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    fork
      monitor();
    join_none

    step();
    step();
    mid();
    check_reset_values("rst");

    // Zero-wait fetch at pc 0.
    step();
    x_reset = 1'b1;
    apply_stimulus(32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    mid();
    check_output("idle_req_valid", 32'(bus.imem_req_valid), 32'h0);
    step();
    mid();
    check_output("req_valid", 32'(bus.imem_req_valid), 32'h1);
    check_output("req_addr", bus.imem_addr, 32'h0);
    step();
    apply_stimulus(32'h0, 1'b0, 1'b1, 1'b1, 32'h0050_0093, 1'b1);
    exp_q.push_back('{inst: 32'h0050_0093, pc: 32'h0, fault: 1'b0, cause: FF_NONE});
    mid();
    check_output("wait_inst_valid", 32'(bus.inst_valid), 32'h0);
    check_output("wait_req_valid", 32'(bus.imem_req_valid), 32'h0);
    check_output("wait_pc_stall", 32'(pc_stall), 32'h1);
    step();
    apply_stimulus(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    mid();
    check_output("hold_inst_valid", 32'(bus.inst_valid), 32'h1);
    check_output("hold_pc_stall", 32'(pc_stall), 32'h0);

    // Memory stalls the request for five cycles at pc 0x10.
    step();
    apply_stimulus(32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      mid();
      check_output("stall_req_valid", 32'(bus.imem_req_valid), 32'h1);
      check_output("stall_addr", bus.imem_addr, 32'h10);
      check_output("stall_inst_valid", 32'(bus.inst_valid), 32'h0);
      check_output("stall_pc_stall", 32'(pc_stall), 32'h1);
      step();
    end
    apply_stimulus(32'h10, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    mid();
    check_output("accept_req_valid", 32'(bus.imem_req_valid), 32'h1);

    // Redirect while waiting; the stale 0xDEADBEEF must be swallowed.
    step();
    apply_stimulus(32'h40, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    mid();
    check_output("flush_req_valid", 32'(bus.imem_req_valid), 32'h0);
    step();
    apply_stimulus(32'h40, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    mid();
    check_output("drop_req_valid", 32'(bus.imem_req_valid), 32'h0);
    step();
    apply_stimulus(32'h40, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
    mid();
    check_output("drop_inst_valid", 32'(bus.inst_valid), 32'h0);
    step();
    apply_stimulus(32'h40, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    mid();
    check_output("redir_req_valid", 32'(bus.imem_req_valid), 32'h1);
    check_output("redir_addr", bus.imem_addr, 32'h40);
    check_output("redir_inst_valid", 32'(bus.inst_valid), 32'h0);
    step();
    apply_stimulus(32'h40, 1'b0, 1'b1, 1'b1, 32'h00A0_0113, 1'b1);
    exp_q.push_back('{inst: 32'h00A0_0113, pc: 32'h40, fault: 1'b0, cause: FF_NONE});
    step();
    apply_stimulus(32'h40, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    mid();
    check_output("redir_hold_valid", 32'(bus.inst_valid), 32'h1);

    // Misaligned pc produces a fault NOP without touching memory.
    step();
    apply_stimulus(32'h102, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    exp_q.push_back('{inst: NOP_INST, pc: 32'h102, fault: 1'b1, cause: FF_MISALIGN});
    mid();
    check_output("misalign_req_valid", 32'(bus.imem_req_valid), 32'h0);
    step();
    apply_stimulus(32'h104, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    mid();
    check_output("misalign_inst_valid", 32'(bus.inst_valid), 32'h1);

    // Silent memory: timeout fault appears five cycles after entering WAIT.
    step();
    apply_stimulus(32'h104, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    mid();
    check_output("to_req_valid", 32'(bus.imem_req_valid), 32'h1);
    step();
    exp_q.push_back('{inst: NOP_INST, pc: 32'h104, fault: 1'b1, cause: FF_TIMEOUT});
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(32'h104, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      mid();
      check_output("to_wait_inst_valid", 32'(bus.inst_valid), 32'h0);
      step();
    end
    apply_stimulus(32'h104, 1'b0, 1'b1, 1'b1, 32'h1111_1111, 1'b0);
    mid();
    check_output("to_inst_valid", 32'(bus.inst_valid), 32'h1);
    check_output("to_cause", 32'(bus.fault_cause), 32'h2);
    check_output("to_inst", bus.inst, NOP_INST);
    step();
    apply_stimulus(32'h104, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    mid();
    check_output("stray_inst", bus.inst, NOP_INST);
    check_output("stray_inst_valid", 32'(bus.inst_valid), 32'h1);

    // Asynchronous reset in WAIT, then a stray response around release.
    step();
    apply_stimulus(32'h200, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    mid();
    check_output("pre_rst_req_valid", 32'(bus.imem_req_valid), 32'h1);
    step();
    #2;
    x_reset = 1'b0;
    #1;
    check_reset_values("async_rst");
    apply_stimulus(32'h300, 1'b0, 1'b1, 1'b1, 32'h2222_2222, 1'b1);
    step();
    step();
    x_reset = 1'b1;
    apply_stimulus(32'h300, 1'b0, 1'b1, 1'b1, 32'h3333_3333, 1'b1);
    mid();
    check_output("rel_idle_req_valid", 32'(bus.imem_req_valid), 32'h0);
    step();
    apply_stimulus(32'h300, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    mid();
    check_output("rel_req_valid", 32'(bus.imem_req_valid), 32'h1);
    check_output("rel_addr", bus.imem_addr, 32'h300);
    check_output("rel_inst_valid", 32'(bus.inst_valid), 32'h0);
    step();
    apply_stimulus(32'h300, 1'b0, 1'b1, 1'b1, 32'h0030_0193, 1'b1);
    exp_q.push_back('{inst: 32'h0030_0193, pc: 32'h300, fault: 1'b0, cause: FF_NONE});
    step();
    apply_stimulus(32'h300, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step();
    step();
    check_output("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
